// File: rtl/mem_dma.sv
// Block copy / block fill engine for the RAM data port.
// Streams one byte per cycle, relying on the RAM's 1-cycle registered read.
module mem_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_read_A,
  output logic          read_en_A,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] addr_write,
  output logic [DW-1:0] data,
  output logic          write_en
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COPY  = 3'd1,
    FILL  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic          mode_r;
  logic [DW-1:0] fill_r;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] wr_ptr_r;

  // Write data: read data passes straight through in copy mode
  always_comb begin
    data = rd_data;
    if (mode_r) begin
      data = fill_r;
    end else begin
      data = rd_data;
    end
  end

  // Transfer sequencer with registered RAM-side controls
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= IDLE;
      mode_r      <= 1'b0;
      fill_r      <= {DW{1'b0}};
      cnt_r       <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      read_en_A   <= 1'b0;
      addr_read_A <= {AW{1'b0}};
      write_en    <= 1'b0;
      addr_write  <= {AW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          read_en_A <= 1'b0;
          write_en  <= 1'b0;
          busy      <= 1'b0;
          if (start) begin
            if (len == {AW{1'b0}}) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              mode_r   <= mode;
              fill_r   <= fill_val;
              cnt_r    <= len;
              busy     <= 1'b1;
              if (mode) begin
                state      <= FILL;
                write_en   <= 1'b1;
                addr_write <= dst;
              end else begin
                state       <= COPY;
                read_en_A   <= 1'b1;
                addr_read_A <= src;
                wr_ptr_r    <= dst;
              end
            end
          end
        end
        COPY: begin
          // Each read's data lands next cycle, so the write trails by one
          write_en   <= 1'b1;
          addr_write <= wr_ptr_r;
          wr_ptr_r   <= wr_ptr_r + AW'(1);
          if (cnt_r == AW'(1)) begin
            state     <= FLUSH;
            read_en_A <= 1'b0;
          end else begin
            cnt_r       <= cnt_r - AW'(1);
            addr_read_A <= addr_read_A + AW'(1);
          end
        end
        FILL: begin
          if (cnt_r == AW'(1)) begin
            state    <= DONE;
            write_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt_r      <= cnt_r - AW'(1);
            addr_write <= addr_write + AW'(1);
          end
        end
        FLUSH: begin
          state    <= DONE;
          write_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          read_en_A <= 1'b0;
          write_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule
